// File: rtl/ms_fpu_mul_div.sv
// ms_fpu_mul_div: iterative 24-bit mantissa shift-add multiplier / restoring divider for the FPU MulDiv port.
module ms_fpu_mul_div #(
   parameter int CMulBits = 24,
   parameter int CDivBits = 29
) (
   input  logic        AClkH,
   input  logic        AResetH,
   input  logic        AClkHEn,
   input  logic [31:0] AMulDivDataS,
   input  logic [31:0] AMulDivDataD,
   input  logic [1:0]  AMulDivStart,
   output logic [31:0] AMulDivDataR,
   output logic [31:0] AMulDivDataH,
   output logic        AMulDivWrEn,
   output logic        ABusy
);
   typedef enum logic [1:0] {Idle, Mul, Div, Done} stateT;
   stateT       state;
   logic [4:0]  cnt;
   logic [23:0] opS, opD, mulHi, mulLo;
   logic [24:0] divRem;
   logic [28:0] quo;
   logic        divErr;
   logic [24:0] mulSum, divSub;
   logic [47:0] prod;
   logic        divGe, startMul, startDiv, startBoth;
   logic        unusedBits;
   assign unusedBits = ^{AMulDivDataS[31:24], AMulDivDataD[31:24]};
   assign startMul   = AMulDivStart == 2'b01;
   assign startDiv   = AMulDivStart == 2'b10;
   assign startBoth  = AMulDivStart == 2'b11;
   // Multiplier shifts out of mulLo while the running sum enters at the top.
   assign mulSum = {1'b0, mulHi} + (mulLo[0] ? {1'b0, opD} : 25'd0);
   assign prod   = {mulSum[24:1], mulSum[0], mulLo[23:1]};
   assign divGe  = divRem >= {1'b0, opS};
   assign divSub = divGe ? divRem - {1'b0, opS} : divRem;
   always_ff @(posedge AClkH or posedge AResetH)
      if (AResetH) begin
         state        <= Idle;
         cnt          <= '0;
         opS          <= '0;
         opD          <= '0;
         mulHi        <= '0;
         mulLo        <= '0;
         divRem       <= '0;
         quo          <= '0;
         divErr       <= 1'b0;
         AMulDivDataR <= '0;
         AMulDivDataH <= '0;
         AMulDivWrEn  <= 1'b0;
         ABusy        <= 1'b0;
      end else if (AClkHEn) begin
         AMulDivWrEn <= 1'b0;
         ABusy       <= 1'b0;
         if (startMul || startDiv) begin
            state  <= startMul ? Mul : Div;
            cnt    <= '0;
            opS    <= AMulDivDataS[23:0];
            opD    <= AMulDivDataD[23:0];
            mulHi  <= '0;
            mulLo  <= AMulDivDataS[23:0];
            divRem <= {1'b0, AMulDivDataD[23:0]};
            quo    <= '0;
            divErr <= AMulDivDataS[23:0] == 24'd0 || {1'b0, AMulDivDataD[23:0]} >= {AMulDivDataS[23:0], 1'b0};
            ABusy  <= 1'b1;
         end else if (startBoth) begin
            state <= Idle;
         end else begin
            case (state)
               Mul: begin
                  mulHi <= mulSum[24:1];
                  mulLo <= {mulSum[0], mulLo[23:1]};
                  cnt   <= cnt + 5'd1;
                  if (cnt == 5'(CMulBits - 1)) begin
                     state        <= Done;
                     AMulDivDataR <= {3'b0, prod[47:19]};
                     AMulDivDataH <= {31'b0, |prod[18:0]};
                     AMulDivWrEn  <= 1'b1;
                  end else ABusy <= 1'b1;
               end
               Div: begin
                  divRem <= {divSub[23:0], 1'b0};
                  quo    <= {quo[27:0], divGe};
                  cnt    <= cnt + 5'd1;
                  if (cnt == 5'(CDivBits - 1)) begin
                     state        <= Done;
                     AMulDivDataR <= divErr ? 32'h1FFFFFFF : {3'b0, quo[27:0], divGe};
                     AMulDivDataH <= divErr ? 32'hFFFFFFFF : {8'b0, divSub[23:0]};
                     AMulDivWrEn  <= 1'b1;
                  end else ABusy <= 1'b1;
               end
               Done:    state <= Idle;
               default: state <= Idle;
            endcase
         end
      end
endmodule

// File: tb/tb_ms_fpu_mul_div.sv
// tb_ms_fpu_mul_div: directed and randomized mul/div checks against an arithmetic reference model.
module tb_ms_fpu_mul_div;
   logic        clk = 1'b0, rst = 1'b1, en = 1'b1;
   logic [31:0] dataS = '0, dataD = '0, dataR, dataH;
   logic [1:0]  start = '0;
   logic        wrEn, busy;
   logic [31:0] lastR, lastH;
   int          compared = 0, mismatched = 0;
   always #5 clk = ~clk;
   ms_fpu_mul_div dut (
      .AClkH(clk), .AResetH(rst), .AClkHEn(en),
      .AMulDivDataS(dataS), .AMulDivDataD(dataD), .AMulDivStart(start),
      .AMulDivDataR(dataR), .AMulDivDataH(dataH), .AMulDivWrEn(wrEn), .ABusy(busy)
   );
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic void model(input logic [1:0] st, input logic [23:0] d, input logic [23:0] s,
                                 output logic [31:0] r, output logic [31:0] h);
      logic [47:0] p;
      longint num;
      if (st == 2'b01) begin
         p = 48'(d) * 48'(s);
         r = {3'b0, p[47:19]};
         h = {31'b0, |p[18:0]};
      end else if (s == 0 || int'(d) >= 2 * int'(s)) begin
         r = 32'h1FFFFFFF;
         h = 32'hFFFFFFFF;
      end else begin
         num = longint'(d) << 28;
         r = 32'(num / longint'(s));
         h = 32'(num % longint'(s));
      end
   endfunction
   task automatic issue(input logic [1:0] st, input logic [23:0] d, input logic [23:0] s);
      en = 1'b1;
      start = st;
      dataD = {8'($urandom), d};
      dataS = {8'($urandom), s};
      tick;
      start = '0;
      dataD = $urandom;
      dataS = $urandom;
   endtask
   // Starts an operation, waits the required enabled edges, checks the result; leaves the DUT in DONE.
   task automatic doOp(input string tag, input logic [1:0] st, input logic [23:0] d, input logic [23:0] s,
                       input int pctEn);
      int lat, n, guard;
      bit early;
      model(st, d, s, lastR, lastH);
      lat = (st == 2'b01) ? 24 : 29;
      issue(st, d, s);
      chk({tag, ":busyAtStart"}, 32'(busy), 32'd1);
      n = 0;
      guard = 0;
      early = 0;
      while (n < lat && guard < 4000) begin
         en = ($urandom_range(99) < pctEn);
         tick;
         guard++;
         if (en) n++;
         if (n < lat && (wrEn || !busy)) early = 1;
      end
      en = 1'b1;
      chk({tag, ":enabledEdges"}, 32'(n), 32'(lat));
      chk({tag, ":earlyOrIdle"}, 32'(early), 32'd0);
      chk({tag, ":wrEn"}, 32'(wrEn), 32'd1);
      chk({tag, ":busyAtDone"}, 32'(busy), 32'd0);
      chk({tag, ":dataR"}, dataR, lastR);
      chk({tag, ":dataH"}, dataH, lastH);
   endtask
   task automatic idleCheck(input string tag);
      start = '0;
      en = 1'b1;
      tick;
      chk({tag, ":wrEnOff"}, 32'(wrEn), 32'd0);
      chk({tag, ":busyOff"}, 32'(busy), 32'd0);
      chk({tag, ":holdR"}, dataR, lastR);
      chk({tag, ":holdH"}, dataH, lastH);
   endtask
   task automatic quiet(input string tag, input int edges);
      bit seen;
      seen = 0;
      for (int i = 0; i < edges; i++) begin
         tick;
         if (wrEn) seen = 1;
      end
      chk({tag, ":noWrEn"}, 32'(seen), 32'd0);
   endtask
   initial begin
      logic [1:0]  st;
      logic [23:0] d, s;
      tick;
      tick;
      chk("reset:dataR", dataR, 32'd0);
      chk("reset:dataH", dataH, 32'd0);
      chk("reset:wrEn", 32'(wrEn), 32'd0);
      chk("reset:busy", 32'(busy), 32'd0);
      #2 rst = 1'b0;
      tick;
      doOp("mulHalf", 2'b01, 24'h800000, 24'h800000, 100);
      chk("mulHalf:const", dataR, 32'h08000000);
      idleCheck("mulHalf");
      doOp("mulMax", 2'b01, 24'hFFFFFF, 24'hFFFFFF, 100);
      chk("mulMax:constR", dataR, 32'h1FFFFFC0);
      chk("mulMax:constH", dataH, 32'd1);
      idleCheck("mulMax");
      doOp("divEq", 2'b10, 24'h800000, 24'h800000, 100);
      chk("divEq:const", dataR, 32'h10000000);
      // Started while still in DONE: chained operation
      doOp("divThird", 2'b10, 24'h800000, 24'hC00000, 100);
      chk("divThird:constR", dataR, 32'h0AAAAAAA);
      chk("divThird:constH", dataH, 32'h00800000);
      idleCheck("divThird");
      doOp("divZero", 2'b10, 24'h800000, 24'h000000, 100);
      idleCheck("divZero");
      doOp("divBig", 2'b10, 24'h800000, 24'h3FFFFF, 100);
      chk("divBig:constH", dataH, 32'hFFFFFFFF);
      idleCheck("divBig");
      issue(2'b01, 24'h123456, 24'h654321);
      for (int i = 0; i < 9; i++) tick;
      doOp("restartDiv", 2'b10, 24'hABCDEF, 24'h987654, 100);
      idleCheck("restartDiv");
      issue(2'b01, 24'hFFFFFF, 24'hFFFFFF);
      for (int i = 0; i < 4; i++) tick;
      #2 rst = 1'b1;
      #1;
      chk("midReset:dataR", dataR, 32'd0);
      chk("midReset:dataH", dataH, 32'd0);
      chk("midReset:busy", 32'(busy), 32'd0);
      #2 rst = 1'b0;
      quiet("midReset", 30);
      lastR = 32'd0;
      lastH = 32'd0;
      issue(2'b01, 24'h800000, 24'h800000);
      for (int i = 0; i < 5; i++) tick;
      start = 2'b11;
      tick;
      start = '0;
      chk("abort11:busy", 32'(busy), 32'd0);
      quiet("abort11", 30);
      start = 2'b11;
      tick;
      start = '0;
      chk("idle11:busy", 32'(busy), 32'd0);
      doOp("mulStall", 2'b01, 24'h800000, 24'h800000, 50);
      en = 1'b0;
      tick;
      chk("mulStall:wrEnFrozen", 32'(wrEn), 32'd1);
      idleCheck("mulStall");
      for (int k = 0; k < 16; k++) begin
         st = 2'($urandom_range(1, 2));
         d  = ($urandom_range(3) == 0) ? 24'($urandom) : {1'b1, 23'($urandom)};
         s  = ($urandom_range(4) == 0) ? 24'($urandom_range(0, 24'h3FFFFF)) : {1'b1, 23'($urandom)};
         doOp($sformatf("rnd%0d", k), st, d, s, ($urandom_range(1) == 1) ? 100 : 50);
         if (k % 2 == 0) idleCheck($sformatf("rnd%0d", k));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
